// File: rtl/mux_writedata_pipe_pkg.sv
// Shared definitions for the registered datapath select muxes: buffer
// occupancy encodings and the selector-width helper.
package mux_writedata_pipe_pkg;

    // Occupancy of the two-entry main/skid output buffer.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    // Number of selector bits needed to address n sources, never below one.
    function automatic int sel_width(input int n);
        int w;
        w = 32'sd1;
        while ((32'sd1 << w) < n) begin
            w = w + 32'sd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mux_writedata_pipe_mux_n_comb.sv
// Purely combinational N_IN-way selector over a packed source bus.
// Codes with no matching source yield all-zero data and raise oor_o, so an
// invalid selector never aliases onto a real source.
module mux_n_comb
    import mux_writedata_pipe_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N_IN  = 6,
    localparam int SEL_W = sel_width(N_IN)
) (
    input  logic [N_IN*WIDTH-1:0] data_i,
    input  logic [SEL_W-1:0]      sel_i,
    output logic [WIDTH-1:0]      data_o,
    output logic                  oor_o
);

    // Scan every source index; only an exact match drives data and clears the flag.
    always_comb begin
        data_o = '0;
        oor_o  = 1'b1;
        for (int k = 0; k < N_IN; k++) begin
            if (sel_i == SEL_W'(k)) begin
                data_o = data_i[k*WIDTH +: WIDTH];
                oor_o  = 1'b0;
            end else begin
                data_o = data_o;
                oor_o  = oor_o;
            end
        end
    end

endmodule

// File: rtl/mux_writedata_pipe.sv
// Registered write-data select mux with a valid/ready output and a two-entry
// skid buffer. The selected value is captured on accept together with its
// selector; every output, including in_ready, comes straight from a flop so
// there is no combinational path between the input and output handshakes.
module mux_writedata_pipe
    import mux_writedata_pipe_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N_IN  = 6,
    localparam int SEL_W = sel_width(N_IN)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_IN*WIDTH-1:0] data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      data_out,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  sel_err,
    input  logic                  err_clr
);

    state_e             state_q,     state_d;
    logic [WIDTH-1:0]   main_data_q, main_data_d;
    logic [SEL_W-1:0]   main_sel_q,  main_sel_d;
    logic [WIDTH-1:0]   skid_data_q, skid_data_d;
    logic [SEL_W-1:0]   skid_sel_q,  skid_sel_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               sel_err_q,   sel_err_d;

    logic [WIDTH-1:0]   mux_data_s;
    logic               mux_oor_s;
    logic               accept_s;
    logic               pop_s;

    mux_n_comb #(
        .WIDTH (WIDTH),
        .N_IN  (N_IN)
    ) u_mux (
        .data_i (data_in),
        .sel_i  (sel),
        .data_o (mux_data_s),
        .oor_o  (mux_oor_s)
    );

    assign accept_s = in_valid && in_ready_q;
    assign pop_s    = out_valid_q && out_ready;

    // Next-state for the buffer occupancy, main/skid entries and the sticky error.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_sel_d  = main_sel_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;

        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    main_data_d = mux_data_s;
                    main_sel_d  = sel;
                    state_d     = ST_ONE;
                end else begin
                    state_d     = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && !pop_s) begin
                    // Output is stalled: park the new item behind main.
                    skid_data_d = mux_data_s;
                    skid_sel_d  = sel;
                    state_d     = ST_TWO;
                end else if (accept_s && pop_s) begin
                    // Streaming: main is consumed and refilled in the same edge.
                    main_data_d = mux_data_s;
                    main_sel_d  = sel;
                    state_d     = ST_ONE;
                end else if (pop_s) begin
                    state_d     = ST_EMPTY;
                end else begin
                    state_d     = ST_ONE;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only a pop can change anything.
                if (pop_s) begin
                    main_data_d = skid_data_q;
                    main_sel_d  = skid_sel_q;
                    state_d     = ST_ONE;
                end else begin
                    state_d     = ST_TWO;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        in_ready_d  = (state_d != ST_TWO);
        out_valid_d = (state_d != ST_EMPTY);

        // A fresh out-of-range accept outranks a simultaneous clear.
        if (accept_s && mux_oor_s) begin
            sel_err_d = 1'b1;
        end else if (err_clr) begin
            sel_err_d = 1'b0;
        end else begin
            sel_err_d = sel_err_q;
        end
    end

    // State and output registers; reset drops all buffered items at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_sel_q  <= '0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_sel_q  <= main_sel_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign data_out  = main_data_q;
    assign out_sel   = main_sel_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_writedata_pipe.sv
// Self-checking bench: directed scenarios plus randomized traffic on a
// default (32x6) instance and an 8x4 instance, each against a queue model.
module tb_mux_writedata_pipe;

    localparam int AW = 32;
    localparam int AN = 6;
    localparam int ASW = 3;
    localparam int BW = 8;
    localparam int BN = 4;
    localparam int BSW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WIDTH=32, N_IN=6
    logic              reset;
    logic              in_valid_a, in_ready_a, out_valid_a, out_ready_a, sel_err_a, err_clr_a;
    logic [ASW-1:0]    sel_a, out_sel_a;
    logic [AN*AW-1:0]  data_in_a;
    logic [AW-1:0]     data_out_a;
    logic [AW-1:0]     src_a [AN];
    assign data_in_a = {src_a[5], src_a[4], src_a[3], src_a[2], src_a[1], src_a[0]};

    // Instance B: WIDTH=8, N_IN=4
    logic              reset_b;
    logic              in_valid_b, in_ready_b, out_valid_b, out_ready_b, sel_err_b, err_clr_b;
    logic [BSW-1:0]    sel_b, out_sel_b;
    logic [BN*BW-1:0]  data_in_b;
    logic [BW-1:0]     data_out_b;
    logic [BW-1:0]     src_b [BN];
    assign data_in_b = {src_b[3], src_b[2], src_b[1], src_b[0]};

    mux_writedata_pipe #(.WIDTH(AW), .N_IN(AN)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .sel(sel_a), .data_in(data_in_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .data_out(data_out_a), .out_sel(out_sel_a), .sel_err(sel_err_a), .err_clr(err_clr_a)
    );

    mux_writedata_pipe #(.WIDTH(BW), .N_IN(BN)) dut_b (
        .clk(clk), .reset(reset_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .sel(sel_b), .data_in(data_in_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .data_out(data_out_b), .out_sel(out_sel_b), .sel_err(sel_err_b), .err_clr(err_clr_b)
    );

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] data;
    } item_t;

    item_t qa[$];
    item_t qb[$];
    bit    fresh_a, fresh_b, err_a, err_b;
    int    checks = 0;
    int    failures = 0;

    // Reference selection: source s if it exists, else zero.
    function automatic logic [31:0] ref_a(input int s);
        logic [31:0] r;
        r = 32'h0;
        for (int k = 0; k < AN; k++) if (k == s) r = src_a[k];
        return r;
    endfunction

    function automatic logic [31:0] ref_b(input int s);
        logic [31:0] r;
        r = 32'h0;
        for (int k = 0; k < BN; k++) if (k == s) r = {24'h0, src_b[k]};
        return r;
    endfunction

    // Advance A one clock and update its FIFO model from the handshake rules.
    task automatic tick_a();
        item_t it;
        bit acc, pop, nerr;
        acc = in_valid_a && !fresh_a && (qa.size() < 2) && reset;
        pop = (qa.size() > 0) && out_ready_a;
        it.sel  = {1'b0, sel_a};
        it.data = ref_a(int'(sel_a));
        nerr = (acc && int'(sel_a) >= AN) ? 1'b1 : (err_clr_a ? 1'b0 : err_a);
        @(posedge clk); #1;
        if (!reset) begin
            qa.delete(); err_a = 1'b0; fresh_a = 1'b1;
        end else begin
            if (pop) void'(qa.pop_front());
            if (acc) qa.push_back(it);
            err_a = nerr; fresh_a = 1'b0;
        end
    endtask

    task automatic tick_b();
        item_t it;
        bit acc, pop, nerr;
        acc = in_valid_b && !fresh_b && (qb.size() < 2) && reset_b;
        pop = (qb.size() > 0) && out_ready_b;
        it.sel  = {2'b0, sel_b};
        it.data = ref_b(int'(sel_b));
        nerr = (acc && int'(sel_b) >= BN) ? 1'b1 : (err_clr_b ? 1'b0 : err_b);
        @(posedge clk); #1;
        if (!reset_b) begin
            qb.delete(); err_b = 1'b0; fresh_b = 1'b1;
        end else begin
            if (pop) void'(qb.pop_front());
            if (acc) qb.push_back(it);
            err_b = nerr; fresh_b = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; reset_b = 1'b0;
        tick_a(); tick_a();
        checks++; if (out_valid_a !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid_a); end
        checks++; if (data_out_a !== 32'h0) begin failures++; $display("FAIL rst_data_out got=%h exp=0", data_out_a); end
        checks++; if (out_sel_a !== 3'd0) begin failures++; $display("FAIL rst_out_sel got=%0d exp=0", out_sel_a); end
        checks++; if (sel_err_a !== 1'b0) begin failures++; $display("FAIL rst_sel_err got=%b exp=0", sel_err_a); end
        checks++; if (in_ready_a !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready_a); end
        reset = 1'b1; reset_b = 1'b1;
        tick_a();
        fresh_b = 1'b0;
        checks++; if (in_ready_a !== 1'b1) begin failures++; $display("FAIL rst_release_in_ready got=%b exp=1", in_ready_a); end
    endtask

    task automatic test_basic();
        for (int k = 0; k < AN; k++) src_a[k] = $urandom;
        src_a[3] = 32'hDEADBEEF;
        sel_a = 3'd3; in_valid_a = 1'b1; out_ready_a = 1'b1;
        tick_a();
        in_valid_a = 1'b0;
        checks++; if (out_valid_a !== 1'b1) begin failures++; $display("FAIL basic_out_valid got=%b exp=1", out_valid_a); end
        checks++; if (data_out_a !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_data got=%h exp=deadbeef", data_out_a); end
        checks++; if (out_sel_a !== 3'd3) begin failures++; $display("FAIL basic_out_sel got=%0d exp=3", out_sel_a); end
        checks++; if (sel_err_a !== 1'b0) begin failures++; $display("FAIL basic_sel_err got=%b exp=0", sel_err_a); end
        tick_a();
        checks++; if (out_valid_a !== 1'b0) begin failures++; $display("FAIL basic_drain got=%b exp=0", out_valid_a); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        for (int k = 0; k < AN; k++) src_a[k] = 32'h1000_0000 + 32'(k);
        out_ready_a = 1'b1; in_valid_a = 1'b1;
        for (int k = 0; k < AN; k++) begin
            sel_a = ASW'(k);
            checks++; if (in_ready_a !== 1'b1) begin failures++; $display("FAIL b2b_in_ready k=%0d got=%b exp=1", k, in_ready_a); end
            tick_a();
            exp = 32'h1000_0000 + 32'(k);
            checks++;
            if (out_valid_a !== 1'b1 || data_out_a !== exp || out_sel_a !== ASW'(k)) begin
                failures++; $display("FAIL b2b_data k=%0d got=%b/%h/%0d exp=1/%h/%0d", k, out_valid_a, data_out_a, out_sel_a, exp, k);
            end
        end
        in_valid_a = 1'b0;
        tick_a();
    endtask

    task automatic test_backpressure();
        src_a[1] = 32'hA1; src_a[2] = 32'hA2;
        out_ready_a = 1'b0; in_valid_a = 1'b1; sel_a = 3'd1;
        tick_a();
        sel_a = 3'd2;
        tick_a();
        in_valid_a = 1'b0;
        checks++; if (in_ready_a !== 1'b0) begin failures++; $display("FAIL bp_in_ready_full got=%b exp=0", in_ready_a); end
        checks++; if (data_out_a !== 32'hA1) begin failures++; $display("FAIL bp_hold_a1 got=%h exp=a1", data_out_a); end
        src_a[1] = 32'h0; src_a[2] = 32'h0;
        tick_a();
        checks++; if (data_out_a !== 32'hA1 || out_sel_a !== 3'd1) begin failures++; $display("FAIL bp_stable got=%h/%0d exp=a1/1", data_out_a, out_sel_a); end
        out_ready_a = 1'b1;
        tick_a();
        checks++; if (data_out_a !== 32'hA2 || out_valid_a !== 1'b1) begin failures++; $display("FAIL bp_second got=%h/%b exp=a2/1", data_out_a, out_valid_a); end
        checks++; if (in_ready_a !== 1'b1) begin failures++; $display("FAIL bp_in_ready_back got=%b exp=1", in_ready_a); end
        tick_a();
        checks++; if (out_valid_a !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", out_valid_a); end
    endtask

    task automatic test_sel_err();
        for (int k = 0; k < AN; k++) src_a[k] = $urandom;
        out_ready_a = 1'b1; in_valid_a = 1'b1; sel_a = 3'd7;
        tick_a();
        in_valid_a = 1'b0;
        checks++; if (data_out_a !== 32'h0 || out_sel_a !== 3'd7) begin failures++; $display("FAIL err_oor_out got=%h/%0d exp=0/7", data_out_a, out_sel_a); end
        checks++; if (sel_err_a !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", sel_err_a); end
        tick_a();
        checks++; if (sel_err_a !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", sel_err_a); end
        err_clr_a = 1'b1;
        tick_a();
        err_clr_a = 1'b0;
        checks++; if (sel_err_a !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", sel_err_a); end
        in_valid_a = 1'b1; sel_a = 3'd6; err_clr_a = 1'b1;
        tick_a();
        in_valid_a = 1'b0; err_clr_a = 1'b0;
        checks++; if (sel_err_a !== 1'b1) begin failures++; $display("FAIL err_set_wins got=%b exp=1", sel_err_a); end
        checks++; if (data_out_a !== 32'h0 || out_sel_a !== 3'd6) begin failures++; $display("FAIL err_sel6_out got=%h/%0d exp=0/6", data_out_a, out_sel_a); end
        err_clr_a = 1'b1;
        tick_a();
        err_clr_a = 1'b0;
        tick_a();
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        src_a[1] = 32'h5555_0001; src_a[2] = 32'h5555_0002;
        out_ready_a = 1'b0; in_valid_a = 1'b1; sel_a = 3'd1;
        tick_a();
        sel_a = 3'd2;
        tick_a();
        in_valid_a = 1'b0;
        checks++; if (in_ready_a !== 1'b0 || out_valid_a !== 1'b1) begin failures++; $display("FAIL mid_two got=%b/%b exp=0/1", in_ready_a, out_valid_a); end
        #3 reset = 1'b0;
        #1;
        checks++; if (out_valid_a !== 1'b0 || data_out_a !== 32'h0) begin failures++; $display("FAIL mid_async got=%b/%h exp=0/0", out_valid_a, data_out_a); end
        checks++; if (out_sel_a !== 3'd0 || in_ready_a !== 1'b0) begin failures++; $display("FAIL mid_async_ctl got=%0d/%b exp=0/0", out_sel_a, in_ready_a); end
        qa.delete(); fresh_a = 1'b1; err_a = 1'b0;
        tick_a();
        reset = 1'b1;
        v = $urandom; src_a[4] = v;
        out_ready_a = 1'b1; in_valid_a = 1'b1; sel_a = 3'd4;
        tick_a();
        checks++; if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin failures++; $display("FAIL mid_release got=%b/%b exp=1/0", in_ready_a, out_valid_a); end
        tick_a();
        in_valid_a = 1'b0;
        checks++; if (out_valid_a !== 1'b1 || data_out_a !== v || out_sel_a !== 3'd4) begin failures++; $display("FAIL mid_first_item got=%b/%h/%0d exp=1/%h/4", out_valid_a, data_out_a, out_sel_a, v); end
        tick_a();
    endtask

    task automatic test_random_a();
        bit rdy_prev;
        for (int c = 0; c < 300; c++) begin
            rdy_prev = !fresh_a && (qa.size() < 2);
            if (!(in_valid_a && !rdy_prev)) begin
                in_valid_a = ($urandom_range(0, 3) != 0);
                sel_a = ASW'($urandom_range(0, 7));
                for (int k = 0; k < AN; k++) src_a[k] = $urandom;
            end
            out_ready_a = ($urandom_range(0, 2) != 0);
            err_clr_a = ($urandom_range(0, 7) == 0);
            tick_a();
            checks++;
            if (out_valid_a !== (qa.size() > 0) || in_ready_a !== (qa.size() < 2) || sel_err_a !== err_a ||
                (qa.size() > 0 && (data_out_a !== qa[0].data || out_sel_a !== qa[0].sel[ASW-1:0]))) begin
                failures++;
                $display("FAIL rand_a c=%0d got v=%b r=%b e=%b d=%h s=%0d exp n=%0d e=%b d=%h s=%0d", c, out_valid_a, in_ready_a,
                         sel_err_a, data_out_a, out_sel_a, qa.size(), err_a, (qa.size() > 0) ? qa[0].data : 32'h0,
                         (qa.size() > 0) ? qa[0].sel : 4'h0);
            end
        end
        in_valid_a = 1'b0; err_clr_a = 1'b0; out_ready_a = 1'b1;
        tick_a(); tick_a();
    endtask

    task automatic test_random_b();
        bit rdy_prev;
        for (int c = 0; c < 1000; c++) begin
            rdy_prev = !fresh_b && (qb.size() < 2);
            if (!(in_valid_b && !rdy_prev)) begin
                in_valid_b = $urandom_range(0, 1) != 0;
                sel_b = BSW'($urandom_range(0, 3));
                for (int k = 0; k < BN; k++) src_b[k] = BW'($urandom);
            end
            out_ready_b = $urandom_range(0, 1) != 0;
            err_clr_b = 1'b0;
            tick_b();
            checks++;
            if (out_valid_b !== (qb.size() > 0) || in_ready_b !== (qb.size() < 2) || sel_err_b !== 1'b0 ||
                (qb.size() > 0 && (data_out_b !== qb[0].data[BW-1:0] || out_sel_b !== qb[0].sel[BSW-1:0]))) begin
                failures++;
                $display("FAIL rand_b c=%0d got v=%b r=%b e=%b d=%h s=%0d exp n=%0d e=0 d=%h s=%0d", c, out_valid_b, in_ready_b,
                         sel_err_b, data_out_b, out_sel_b, qb.size(), (qb.size() > 0) ? qb[0].data : 32'h0,
                         (qb.size() > 0) ? qb[0].sel : 4'h0);
            end
        end
    endtask

    initial begin
        reset = 1'b1; reset_b = 1'b1;
        in_valid_a = 1'b0; out_ready_a = 1'b0; err_clr_a = 1'b0; sel_a = '0;
        in_valid_b = 1'b0; out_ready_b = 1'b0; err_clr_b = 1'b0; sel_b = '0;
        for (int k = 0; k < AN; k++) src_a[k] = '0;
        for (int k = 0; k < BN; k++) src_b[k] = '0;
        fresh_a = 1'b1; fresh_b = 1'b1; err_a = 1'b0; err_b = 1'b0;
        #2;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_sel_err();
        test_reset_mid();
        test_random_a();
        test_random_b();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_writedata_pipe.md
Name: mux_writedata_pipe

Overview:
- Parametrised, registered successor to the write-data select mux in the datapath.
- Selects one of N_IN packed WIDTH-bit sources per transaction and presents the result on a valid/ready output.
- A 2-entry skid buffer gives full throughput under backpressure.
- Out-of-range selector codes are flagged, not silently aliased.
- Sits between the functional-unit results (ALU, memory data, HI/LO, shifter, immediates, link PC) and register-file write-back.

Parameters:
- WIDTH, 32, bit width of each source and of the output.
- N_IN, 6, number of sources (2..16).
- SEL_W, derived as clog2(N_IN) with a minimum of 1. Localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset. 0 = reset asserted.
- in_valid  in  1  source transaction valid.
- in_ready  out  1  block can accept a transaction this cycle.
- sel  in  SEL_W  source index, sampled with the transaction.
- data_in  in  N_IN*WIDTH  packed sources; source k occupies bits [k*WIDTH +: WIDTH].
- out_valid  out  1  data_out/out_sel hold a valid result.
- out_ready  in  1  consumer accepts the result this cycle.
- data_out  out  WIDTH  selected data.
- out_sel  out  SEL_W  selector that produced data_out.
- sel_err  out  1  sticky: an out-of-range sel was accepted.
- err_clr  in  1  synchronous clear of sel_err.

Behaviour:
- Accept occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- On accept: mux value = data_in slice sel if sel < N_IN, else all-zero. Captured together with sel.
- Latency: an accepted item appears on data_out on the next rising edge when the block was empty. No combinational path from in_* to out_*.
- Storage is two entries: main (drives outputs) and skid.
- FSM states: EMPTY, ONE (main valid), TWO (main and skid valid).
  - EMPTY: accept -> ONE.
  - ONE: accept without pop -> TWO, item goes to skid. Pop without accept -> EMPTY. Accept with pop -> ONE, main reloads from the new item.
  - TWO: pop -> ONE, main <= skid. Accept is impossible in TWO.
- in_ready = (state != TWO), driven from a register, so there is no out_ready->in_ready combinational path.
- out_valid = (state != EMPTY). data_out and out_sel stay stable while out_valid && !out_ready.
- Throughput is 1 item/cycle when out_ready is held high. Order is strictly FIFO.
- sel_err:
  - Set on the edge after accepting sel >= N_IN.
  - Cleared by err_clr. If set and clear occur in the same cycle, set wins.
  - For power-of-two N_IN no code is out of range, so sel_err stays 0.
- Reset (asynchronous assert, synchronous-release expected upstream): state=EMPTY, in_ready=0 during reset and 1 on the first cycle after deassertion. out_valid=0, data_out=0, out_sel=0, sel_err=0.
- Reset asserted mid-transaction discards all buffered items. No partial output.
- in_valid with in_ready=0 has no effect. The source must hold its data, and the block does not latch it.

Decomposition:
- Shared package / include: state encodings (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2) and the SEL_W clog2 function, reused by other datapath muxes.
- One natural sub-module: mux_n_comb, a purely combinational WIDTH x N_IN selector with an out-of-range flag. It replaces the hand-cascaded ternary trees.
- The top level holds the FSM, main/skid registers and sel_err.

Test Plan:
1. Reset, then in_valid=1, sel=3, data_in[3]=32'hDEADBEEF, out_ready=1 -> next cycle out_valid=1, data_out=32'hDEADBEEF, out_sel=3, sel_err=0.
2. Stream sel=0..5 back-to-back with source k = 32'h1000_000k and out_ready=1 -> six consecutive outputs 0x10000000..0x10000005, in_ready never drops.
3. out_ready=0, accept two items (sel=1: 0xA1, sel=2: 0xA2) -> in_ready=0 in cycle 3, data_out holds 0xA1. Raise out_ready -> 0xA1 then 0xA2, in_ready returns to 1.
4. sel=7 with N_IN=6 -> data_out=0, out_sel=7, sel_err=1 and held. Pulse err_clr -> sel_err=0. Repeat with sel=6 and err_clr in the same cycle -> sel_err=1.
5. Hold state TWO, assert reset mid-cycle -> out_valid=0, data_out=0 immediately (asynchronous). After release, in_ready=1, and the first new item is output with no stale data.
6. Instantiate WIDTH=8, N_IN=4, random valid/ready for 1000 cycles -> a scoreboard matches order and data, and sel_err stays 0.
